// File: rtl/sar_search4.sv
// rtl/sar_search4.sv - successive-approximation search against an external comparator
// One result bit is resolved per TEST cycle, MSB first; O is loaded when bit 0 resolves.
module sar_search4 #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         ABORT,
  input  logic         LE,
  output logic [N-1:0] TRIAL,
  output logic [N-1:0] O,
  output logic         BUSY,
  output logic         DONE
);

  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_TOP = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    TEST,
    FIN
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  trial_q, trial_d;
  logic [N-1:0]  o_q, o_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] k_m1;

  assign k_m1 = k_q - KW'(1);

  always_comb begin
    state_d = state_q;
    trial_d = trial_q;
    o_d     = o_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        trial_d = '0;
        k_d     = K_TOP;
        if (START && !ABORT) begin
          state_d = TEST;
          trial_d = {1'b1, {(N-1){1'b0}}};
        end
      end
      TEST: begin
        if (ABORT) begin
          state_d = IDLE;
          trial_d = '0;
          k_d     = K_TOP;
        end else begin
          // The trial bit is currently 1, so keeping or clearing it is just LE.
          trial_d[k_q] = LE;
          if (k_q != '0) begin
            trial_d[k_m1] = 1'b1;
            k_d           = k_m1;
          end else begin
            state_d = FIN;
            o_d     = trial_d;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        trial_d = '0;
        k_d     = K_TOP;
      end
      default: begin
        state_d = IDLE;
        trial_d = '0;
        k_d     = K_TOP;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      trial_q <= '0;
      o_q     <= '0;
      k_q     <= K_TOP;
    end else begin
      state_q <= state_d;
      trial_q <= trial_d;
      o_q     <= o_d;
      k_q     <= k_d;
    end
  end

  assign TRIAL = trial_q;
  assign O     = o_q;
  assign BUSY  = (state_q == TEST);
  assign DONE  = (state_q == FIN);

endmodule
